// File: rtl/fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_ctrl
// Purpose  : Single-clock FIFO with internal read/write pointers, a registered
//            occupancy count, almost-full/almost-empty thresholds, sticky
//            overflow/underflow flags and a synchronous flush (clr).
// Config   : FIFO_FWFT_EN - when defined, data_out is the head word shown
//            combinationally (first-word fall-through). When undefined,
//            data_out is a register loaded on each accepted read.
// Ports    : clk          - clock, all logic on posedge
//            rst          - asynchronous active-high reset
//            clr          - synchronous flush, priority over w_en/r_en
//            w_en/data_in - write request and write data
//            r_en         - read request (pop acknowledge in FWFT mode)
//            data_out     - read data
//            fifo_full, fifo_empty, almost_full, almost_empty - status flags
//            count        - occupancy 0..DEPTH
//            overflow     - sticky, write attempted while full
//            underflow    - sticky, read attempted while empty
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_AFULL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] c_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] c_ONE    = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_ok, rd_ok;

  // Flags come only from the count register, so no request input reaches
  // a flag without passing through a flop.
  assign fifo_full    = (count_q == c_DEPTH);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= c_AFULL);
  assign almost_empty = (count_q <= c_AEMPTY);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A flush suppresses both accesses.
  assign wr_ok = w_en & ~fifo_full & ~clr;
  assign rd_ok = r_en & ~fifo_empty & ~clr;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + c_ONE;
      if (rd_ok) rptr_d = rptr_q + c_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + c_ONE;
        2'b01:   count_d = count_q - c_ONE;
        default: count_d = count_q;
      endcase
      // Rejected write-while-full / read-while-empty latch the error.
      if (w_en & fifo_full)  ovf_d = 1'b1;
      if (r_en & fifo_empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q[ADDR_WIDTH-1:0]] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word is always visible; a pop advances rptr and the next word
  // appears after that edge.
  assign data_out = mem[rptr_q[ADDR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else if (clr) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
    end
  end

  assign data_out = dout_q;
`endif

endmodule
`default_nettype wire
